// File: rtl/avalon_mem_agent.sv
// Avalon-MM responder backed by an on-chip word RAM, with single and burst reads/writes.
// Optional AVALON_MEM_AGENT_ERR_RESP_EN: out-of-range beats get SLAVEERROR / dropped writes.
module avalon_mem_agent #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MEM_WORDS  = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writedata,
    input  logic [DATA_WIDTH-1:0] burstcount,
    input  logic                  beginbursttransfer,
    output logic                  waitrequest,
    output logic                  readdatavalid,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic [1:0]            response
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [IDX_W-1:0]      beat_idx;
    logic                  beat_in_range;
    logic [DATA_WIDTH-1:0] beat_rdata;
    logic [1:0]            beat_resp;
    logic                  bc_multi;
    logic                  mem_we;
    logic                  unused_bits;

`ifdef AVALON_MEM_AGENT_ERR_RESP_EN
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS);
`endif

    // First beat addresses come from the bus, later beats from the burst counter.
    always_comb begin
        beat_addr = (state == IDLE) ? address : addr;
        beat_idx  = beat_addr[IDX_W-1:0];
`ifdef AVALON_MEM_AGENT_ERR_RESP_EN
        beat_in_range = ({1'b0, beat_addr} < MEM_LIMIT);
        beat_rdata    = beat_in_range ? mem[beat_idx] : '0;
        beat_resp     = beat_in_range ? 2'b00 : 2'b10;
`else
        beat_in_range = 1'b1;
        beat_rdata    = mem[beat_idx];
        beat_resp     = 2'b00;
`endif
        bc_multi = (burstcount > DATA_WIDTH'(1));
        mem_we   = write && !waitrequest && (state != RD_BURST) && beat_in_range;
    end

    assign unused_bits = &{1'b0, beginbursttransfer, beat_addr};

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[beat_idx] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            addr          <= '0;
            rem           <= '0;
            waitrequest   <= 1'b1;
            readdatavalid <= 1'b0;
            readdata      <= '0;
            response      <= 2'b00;
        end else begin
            readdatavalid <= 1'b0;
            case (state)
                IDLE: begin
                    waitrequest <= 1'b0;
                    if (!waitrequest && write) begin
                        // write wins over a simultaneous read
                        if (bc_multi) begin
                            addr  <= beat_addr + ADDR_WIDTH'(1);
                            rem   <= burstcount - DATA_WIDTH'(1);
                            state <= WR_BURST;
                        end
                    end else if (!waitrequest && read) begin
                        readdata      <= beat_rdata;
                        response      <= beat_resp;
                        readdatavalid <= 1'b1;
                        if (bc_multi) begin
                            addr        <= beat_addr + ADDR_WIDTH'(1);
                            rem         <= burstcount - DATA_WIDTH'(1);
                            state       <= RD_BURST;
                            waitrequest <= 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    waitrequest <= 1'b0;
                    if (write) begin
                        addr <= addr + ADDR_WIDTH'(1);
                        rem  <= rem - DATA_WIDTH'(1);
                        if (rem == DATA_WIDTH'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    readdata      <= beat_rdata;
                    response      <= beat_resp;
                    readdatavalid <= 1'b1;
                    addr          <= addr + ADDR_WIDTH'(1);
                    rem           <= rem - DATA_WIDTH'(1);
                    // drop waitrequest with the last beat so the next command overlaps it
                    if (rem == DATA_WIDTH'(1)) begin
                        state       <= IDLE;
                        waitrequest <= 1'b0;
                    end else begin
                        waitrequest <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    waitrequest <= 1'b0;
                end
            endcase
        end
    end

endmodule
